// File: rtl/fp32_unpacker.sv
// IEEE-754 float32 unpacker: sign, unbiased exponent, 24-bit mantissa, class flags.
// Define FP32_UNPACK_FTZ_EN to flush subnormals to zero instead of normalising them.
module fp32_unpacker #(
    parameter int EXP_W = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sig,
    output logic signed [EXP_W-1:0] exp,
    output logic [23:0]             mant,
    output logic                    nan,
    output logic                    inf,
    output logic                    zero
);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } state_t;

    localparam logic [EXP_W-1:0] EXP_BIAS = EXP_W'(127);
    localparam logic [EXP_W-1:0] EXP_MAX  = EXP_W'(128);
`ifndef FP32_UNPACK_FTZ_EN
    localparam logic [EXP_W-1:0] EXP_SUB  = EXP_W'(-126);
`endif

    state_t                    state;
    state_t                    state_n;
    logic                      sig_n;
    logic signed [EXP_W-1:0]   exp_n;
    logic [23:0]               mant_n;
    logic                      nan_n;
    logic                      inf_n;
    logic                      zero_n;

    logic [7:0]                e_fld;
    logic [22:0]               f_fld;
    logic                      accept;
    logic                      is_spec;
    logic                      is_norm;
    logic                      is_zero;
    logic                      is_sub;

    assign e_fld   = in_data[30:23];
    assign f_fld   = in_data[22:0];
    assign is_spec = (e_fld == 8'hFF);
    assign is_norm = (e_fld != 8'h00) && (e_fld != 8'hFF);
    assign is_zero = (e_fld == 8'h00) && (f_fld == 23'd0);
    assign is_sub  = (e_fld == 8'h00) && (f_fld != 23'd0);

    assign in_ready  = ~rst & ((state == IDLE) | ((state == DONE) & out_ready));
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;

    // Next state and next result fields; everything holds unless updated.
    always_comb begin
        state_n = state;
        sig_n   = sig;
        exp_n   = exp;
        mant_n  = mant;
        nan_n   = nan;
        inf_n   = inf;
        zero_n  = zero;
        if (state == NORM) begin
`ifndef FP32_UNPACK_FTZ_EN
            mant_n = {mant[22:0], 1'b0};
            exp_n  = exp - EXP_W'(1);
            if (mant[22]) begin
                state_n = DONE;
            end
`endif
        end else if (accept) begin
            sig_n   = in_data[31];
            nan_n   = 1'b0;
            inf_n   = 1'b0;
            zero_n  = 1'b0;
            state_n = DONE;
            unique case (1'b1)
                is_spec: begin
                    exp_n  = EXP_MAX;
                    mant_n = {1'b1, f_fld};
                    nan_n  = |f_fld;
                    inf_n  = ~|f_fld;
                end
                is_norm: begin
                    exp_n  = EXP_W'(e_fld) - EXP_BIAS;
                    mant_n = {1'b1, f_fld};
                end
                is_zero: begin
                    exp_n  = '0;
                    mant_n = '0;
                    zero_n = 1'b1;
                end
                is_sub: begin
`ifdef FP32_UNPACK_FTZ_EN
                    exp_n  = '0;
                    mant_n = '0;
                    zero_n = 1'b1;
`else
                    exp_n   = EXP_SUB;
                    mant_n  = {1'b0, f_fld};
                    state_n = NORM;
`endif
                end
                default: begin
                    state_n = DONE;
                end
            endcase
        end else if ((state == DONE) && out_ready) begin
            state_n = IDLE;
        end
    end

    // State and result registers; reset discards any in-flight result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sig   <= 1'b0;
            exp   <= '0;
            mant  <= '0;
            nan   <= 1'b0;
            inf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            state <= state_n;
            sig   <= sig_n;
            exp   <= exp_n;
            mant  <= mant_n;
            nan   <= nan_n;
            inf   <= inf_n;
            zero  <= zero_n;
        end
    end

endmodule

// File: tb/tb_fp32_unpacker.sv
// Randomised self-checking bench for fp32_unpacker against a float32 class model.
// Honours FP32_UNPACK_FTZ_EN in the model when the design is built with it.
module tb_fp32_unpacker;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic              out_valid;
    logic              out_ready;
    logic              sig;
    logic signed [9:0] exp_o;
    logic [23:0]       mant;
    logic              nan;
    logic              inf;
    logic              zero;

    int checks;
    int errors;

    fp32_unpacker #(.EXP_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sig       (sig),
        .exp       (exp_o),
        .mant      (mant),
        .nan       (nan),
        .inf       (inf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, $signed(got), $signed(want));
        end
    endtask

    // Expected result of unpacking w, from the float32 encoding rules.
    function automatic void model(input logic [31:0] w, output logic s,
                                  output int e, output logic [23:0] m,
                                  output logic fn, output logic fi,
                                  output logic fz, output int lat);
        int ef;
        int f;
        ef = int'(w[30:23]);
        f  = int'(w[22:0]);
        s  = w[31];
        e  = 0;
        m  = '0;
        fn = 1'b0;
        fi = 1'b0;
        fz = 1'b0;
        lat = 1;
        if (ef == 255) begin
            e  = 128;
            m  = 24'(8388608 + f);
            fn = (f != 0);
            fi = (f == 0);
        end else if (ef == 0 && f == 0) begin
            fz = 1'b1;
        end else if (ef == 0) begin
`ifdef FP32_UNPACK_FTZ_EN
            fz = 1'b1;
`else
            int k;
            k   = $clog2(f + 1) - 1;
            m   = 24'(f * (2 ** (23 - k)));
            e   = -149 + k;
            lat = 24 - k;
`endif
        end else begin
            e = ef - 127;
            m = 24'(8388608 + f);
        end
    endfunction

    task automatic chk_fields(input string tag, input logic [31:0] w);
        logic        s, fn, fi, fz;
        int          e, lat;
        logic [23:0] m;
        model(w, s, e, m, fn, fi, fz, lat);
        chk({tag, ".valid"}, 64'(out_valid), 64'(1));
        chk({tag, ".sig"}, 64'(sig), 64'(s));
        chk({tag, ".exp"}, 64'(int'(exp_o)), 64'(e));
        chk({tag, ".mant"}, 64'(mant), 64'(m));
        chk({tag, ".flags"}, 64'({nan, inf, zero}), 64'({fn, fi, fz}));
    endtask

    // Send one operand with out_ready high and check latency and fields.
    task automatic run_op(input string tag, input logic [31:0] w);
        logic        s, fn, fi, fz;
        int          e, lat, want_lat, n;
        logic [23:0] m;
        model(w, s, e, m, fn, fi, fz, want_lat);
        @(negedge clk);
        in_data  = w;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(1));
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            chk({tag, ".busy"}, 64'(in_ready), 64'(0));
            @(negedge clk);
            lat++;
        end
        chk({tag, ".lat"}, 64'(lat), 64'(want_lat));
        chk_fields(tag, w);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int          c;
        w = $urandom;
        c = int'($urandom_range(0, 7));
        case (c)
            0: w[30:23] = 8'h00;
            1: begin
                w[30:23] = 8'h00;
                w[22:0]  = 23'(1) << $urandom_range(0, 22);
            end
            2: w[30:0] = {8'h00, 23'd0};
            3: w[30:23] = 8'hFF;
            4: w[30:0] = {8'hFF, 23'd0};
            default: begin
            end
        endcase
        return w;
    endfunction

    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [63:0] snap;
    bit          saw_valid;

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.valid", 64'(out_valid), 64'(0));
        chk("rst.fields", 64'({sig, exp_o, mant, nan, inf, zero}), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("rst.in_ready", 64'(in_ready), 64'(1));

        // Back-to-back normals.
        w_a = 32'h3F800000;
        w_b = 32'hC0490FDB;
        in_data  = w_a;
        in_valid = 1'b1;
        @(negedge clk);
        chk_fields("one", w_a);
        chk("b2b.in_ready", 64'(in_ready), 64'(1));
        in_data = w_b;
        @(negedge clk);
        chk_fields("pi", w_b);
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b.drop", 64'(out_valid), 64'(0));

        // Directed subnormals and specials.
        run_op("sub1", 32'h00000001);
        run_op("sub22", 32'h00400000);
        run_op("ninf", 32'hFF800000);
        run_op("nan", 32'h7FC00001);
        run_op("nzero", 32'h80000000);
        run_op("maxn", 32'h7F7FFFFF);
        run_op("minn", 32'h00800000);

        // Backpressure: result held while out_ready is low.
        w_a = 32'h41200000;
        w_b = 32'hBF000000;
        @(negedge clk);
        out_ready = 1'b0;
        in_data   = w_a;
        in_valid  = 1'b1;
        @(negedge clk);
        chk_fields("bp", w_a);
        snap = 64'({sig, exp_o, mant, nan, inf, zero});
        in_data = w_b;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.hold", 64'({sig, exp_o, mant, nan, inf, zero}), snap);
            chk("bp.in_ready", 64'(in_ready), 64'(0));
            chk("bp.valid", 64'(out_valid), 64'(1));
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release", 64'(in_ready), 64'(1));
        @(negedge clk);
        chk_fields("bp2", w_b);
        in_valid = 1'b0;
        @(negedge clk);

        // Reset during normalisation discards the result.
        in_data  = 32'h00000001;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid.valid", 64'(out_valid), 64'(0));
        chk("mid.fields", 64'({sig, exp_o, mant, nan, inf, zero}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid.in_ready", 64'(in_ready), 64'(1));
        saw_valid = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        chk("mid.stale", 64'(saw_valid), 64'(0));
        run_op("post", 32'h3F800000);

        // Randomised operands.
        for (int i = 0; i < 200; i++) begin
            run_op("rnd", rand_word());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
